copcom_endpoint: RTL and testbench

COPCOM-side endpoint of the Pico memory-mapped COPCOM register set. It consumes the 8-bit control registers driven by the MMI bridge and produces the 8-bit status/data registers the bridge reads back. It contains three functions: a CRC-16 engine, a transmit byte FIFO drained onto a valid/ready byte stream, and a receive byte FIFO filled from a valid/ready byte stream and popped by the CPU.

---
 rtl/copcom_pkg.sv | 44 ++++
 rtl/copcom_if.sv | 43 ++++
 rtl/copcom_fifo.sv | 52 +++++
 rtl/copcom_endpoint.sv | 186 ++++++++++++++++++
 tb/tb_copcom_endpoint.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/copcom_pkg.sv
// Shared constants, command/status bit positions, CRC FSM states and a CRC
// bit-step helper for the COPCOM endpoint.
package copcom_pkg;

  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned CRC_W        = 16;
  localparam int unsigned WRSTAT_CNT_W = 5;

  localparam logic [CRC_W-1:0] CRC_POLY_DEF = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_SEED_DEF = 16'hFFFF;

  // Command register bit indices
  localparam int unsigned CRCEN_LOAD = 0;
  localparam int unsigned CRCEN_PROC = 1;
  localparam int unsigned CRCEN_TWO  = 2;
  localparam int unsigned WREN_PUSH  = 0;
  localparam int unsigned WREN_SEND  = 1;
  localparam int unsigned RDEN_POP   = 0;
  localparam int unsigned CLR        = 7;

  // Status register bit positions
  localparam int unsigned CRCSTAT_BUSY   = 0;
  localparam int unsigned CRCSTAT_DONE   = 1;
  localparam int unsigned WRSTAT_SENDING = 5;
  localparam int unsigned WRSTAT_OVF     = 6;
  localparam int unsigned WRSTAT_UNR     = 7;
  localparam int unsigned RDSTAT_EMPTY   = 0;
  localparam int unsigned RDSTAT_FULL    = 1;
  localparam int unsigned RDSTAT_UDF     = 2;

  typedef enum logic [1:0] {
    CRC_IDLE   = 2'd0,
    CRC_SHIFT1 = 2'd1,
    CRC_SHIFT2 = 2'd2
  } crc_state_e;

  // One MSB-first CRC step for a single data bit
  function automatic logic [CRC_W-1:0] crc_bit(input logic [CRC_W-1:0] crc,
                                               input logic             din,
                                               input logic [CRC_W-1:0] poly);
    return {crc[CRC_W-2:0], 1'b0} ^ ((crc[CRC_W-1] ^ din) ? poly : '0);
  endfunction

endpackage

// File: rtl/copcom_if.sv
// COPCOM register set plus the outbound/inbound byte streams, as seen between
// the MMI bridge side (master) and the endpoint (slave).
interface copcom_if;
  import copcom_pkg::*;

  logic [BYTE_W-1:0] COPCRCEN;
  logic [BYTE_W-1:0] COPCRCINIT1;
  logic [BYTE_W-1:0] COPCRCINIT2;
  logic [BYTE_W-1:0] COPCRCI1;
  logic [BYTE_W-1:0] COPCRCI2;
  logic [BYTE_W-1:0] COPWR;
  logic [BYTE_W-1:0] COPWREN;
  logic [BYTE_W-1:0] COPWRLN;
  logic [BYTE_W-1:0] COPRDEN;
  logic [BYTE_W-1:0] COPCRCSTAT;
  logic [BYTE_W-1:0] COPCRCO1;
  logic [BYTE_W-1:0] COPCRCO2;
  logic [BYTE_W-1:0] COPWRSTAT;
  logic [BYTE_W-1:0] COPRD;
  logic [BYTE_W-1:0] COPRDLN;
  logic [BYTE_W-1:0] COPRDSTAT;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output COPCRCEN, COPCRCINIT1, COPCRCINIT2, COPCRCI1, COPCRCI2,
           COPWR, COPWREN, COPWRLN, COPRDEN, tx_ready, rx_data, rx_valid,
    input  COPCRCSTAT, COPCRCO1, COPCRCO2, COPWRSTAT, COPRD, COPRDLN,
           COPRDSTAT, tx_data, tx_valid, rx_ready
  );

  modport slave (
    input  COPCRCEN, COPCRCINIT1, COPCRCINIT2, COPCRCI1, COPCRCI2,
           COPWR, COPWREN, COPWRLN, COPRDEN, tx_ready, rx_data, rx_valid,
    output COPCRCSTAT, COPCRCO1, COPCRCO2, COPWRSTAT, COPRD, COPRDLN,
           COPRDSTAT, tx_data, tx_valid, rx_ready
  );

endinterface

// File: rtl/copcom_fifo.sv
// Synchronous byte FIFO with first-word fall-through head; head reads 0 when empty.
module copcom_fifo
  import copcom_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [BYTE_W-1:0]            wdata,
  output logic [BYTE_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_en;
  logic              push_en;

  // A push into a full FIFO only lands if a pop frees a slot in the same cycle
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    pop_en  = pop & ~empty;
    push_en = push & (~full | pop_en);
    head    = empty ? '0 : mem[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
    end
  end

endmodule

// File: rtl/copcom_endpoint.sv
// COPCOM endpoint: CRC-16 engine, TX FIFO drained onto a byte stream, and RX
// FIFO filled from a byte stream, all driven by rising edges of command bits.
module copcom_endpoint
  import copcom_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH   = 16,
  parameter logic [CRC_W-1:0] CRC_POLY     = CRC_POLY_DEF,
  parameter logic [CRC_W-1:0] CRC_SEED_RST = CRC_SEED_DEF
) (
  input  logic     clk,
  input  logic     rst,
  copcom_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [BYTE_W-1:0] crcen_prev, wren_prev, rden_prev;
  logic [BYTE_W-1:0] crcen_rise, wren_rise, rden_rise;
  logic              unused_bits;

  // prev follows the inputs every cycle, including during reset
  always_ff @(posedge clk) begin
    crcen_prev <= bus.COPCRCEN;
    wren_prev  <= bus.COPWREN;
    rden_prev  <= bus.COPRDEN;
  end

  assign crcen_rise  = bus.COPCRCEN & ~crcen_prev;
  assign wren_rise   = bus.COPWREN  & ~wren_prev;
  assign rden_rise   = bus.COPRDEN  & ~rden_prev;
  assign unused_bits = ^{crcen_rise[7:3], wren_rise[6:2], rden_rise[6:1]};

  // ---------------- CRC engine ----------------
  crc_state_e        state;
  logic [2:0]        bit_cnt;
  logic [CRC_W-1:0]  crc;
  logic [BYTE_W-1:0] d1, d2;
  logic              two, done, shift_bit;

  assign shift_bit = (state == CRC_SHIFT2) ? d2[3'd7 - bit_cnt] : d1[3'd7 - bit_cnt];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CRC_IDLE;
      bit_cnt <= '0;
      crc     <= CRC_SEED_RST;
      d1      <= '0;
      d2      <= '0;
      two     <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        CRC_IDLE: begin
          if (crcen_rise[CRCEN_LOAD]) begin
            crc  <= {bus.COPCRCINIT1, bus.COPCRCINIT2};
            done <= 1'b0;
          end else if (crcen_rise[CRCEN_PROC]) begin
            d1      <= bus.COPCRCI1;
            d2      <= bus.COPCRCI2;
            two     <= bus.COPCRCEN[CRCEN_TWO];
            done    <= 1'b0;
            bit_cnt <= '0;
            state   <= CRC_SHIFT1;
          end
        end
        CRC_SHIFT1, CRC_SHIFT2: begin
          crc     <= crc_bit(crc, shift_bit, CRC_POLY);
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == CRC_SHIFT1 && two) begin
              state <= CRC_SHIFT2;
            end else begin
              state <= CRC_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= CRC_IDLE;
      endcase
    end
  end

  // ---------------- TX path ----------------
  logic [BYTE_W-1:0] tx_head;
  logic [CNT_W-1:0]  tx_count;
  logic              tx_full, tx_empty, tx_push, tx_pop;
  logic              sending, tx_ovf, tx_unr;
  logic [BYTE_W-1:0] tx_len;

  assign bus.tx_valid = sending & ~tx_empty;
  assign bus.tx_data  = tx_head;
  assign tx_pop       = bus.tx_valid & bus.tx_ready;
  assign tx_push      = wren_rise[WREN_PUSH] & (~tx_full | tx_pop);

  copcom_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .wdata (bus.COPWR),
    .head  (tx_head),
    .count (tx_count),
    .full  (tx_full),
    .empty (tx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sending <= 1'b0;
      tx_len  <= '0;
      tx_ovf  <= 1'b0;
      tx_unr  <= 1'b0;
    end else begin
      if (wren_rise[CLR]) begin
        tx_ovf <= 1'b0;
        tx_unr <= 1'b0;
      end
      if (wren_rise[WREN_PUSH] && tx_full && !tx_pop) tx_ovf <= 1'b1;
      if (sending) begin
        if (tx_pop) begin
          tx_len <= tx_len - 8'd1;
          if (tx_len == 8'd1) sending <= 1'b0;
        end
      end else if (wren_rise[WREN_SEND]) begin
        // A send longer than what is buffered is refused up front
        if (bus.COPWRLN == '0 || bus.COPWRLN > BYTE_W'(tx_count)) begin
          tx_unr <= 1'b1;
        end else begin
          sending <= 1'b1;
          tx_len  <= bus.COPWRLN;
        end
      end
    end
  end

  // ---------------- RX path ----------------
  logic [BYTE_W-1:0] rx_head;
  logic [CNT_W-1:0]  rx_count;
  logic              rx_full, rx_empty, rx_push, rx_pop, rx_udf;

  assign bus.rx_ready = ~rx_full;
  assign rx_push      = bus.rx_valid & ~rx_full;
  assign rx_pop       = rden_rise[RDEN_POP] & ~rx_empty;

  copcom_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (rx_pop),
    .wdata (bus.rx_data),
    .head  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_udf <= 1'b0;
    end else begin
      if (rden_rise[CLR]) rx_udf <= 1'b0;
      if (rden_rise[RDEN_POP] && rx_empty) rx_udf <= 1'b1;
    end
  end

  // ---------------- Status/data registers ----------------
  always_comb begin
    bus.COPCRCSTAT = '0;
    bus.COPWRSTAT  = '0;
    bus.COPRDSTAT  = '0;
    bus.COPCRCSTAT[CRCSTAT_BUSY]          = (state != CRC_IDLE);
    bus.COPCRCSTAT[CRCSTAT_DONE]          = done;
    bus.COPWRSTAT[WRSTAT_CNT_W-1:0]       = WRSTAT_CNT_W'(tx_count);
    bus.COPWRSTAT[WRSTAT_SENDING]         = sending;
    bus.COPWRSTAT[WRSTAT_OVF]             = tx_ovf;
    bus.COPWRSTAT[WRSTAT_UNR]             = tx_unr;
    bus.COPRDSTAT[RDSTAT_EMPTY]           = rx_empty;
    bus.COPRDSTAT[RDSTAT_FULL]            = rx_full;
    bus.COPRDSTAT[RDSTAT_UDF]             = rx_udf;
    bus.COPCRCO1 = crc[15:8];
    bus.COPCRCO2 = crc[7:0];
    bus.COPRD    = rx_head;
    bus.COPRDLN  = BYTE_W'(rx_count);
  end

endmodule

// File: tb/tb_copcom_endpoint.sv
// Self-checking bench for copcom_endpoint: CRC, TX send/flags, RX fill/drain
// and reset behaviour against a byte-level reference model.
module tb_copcom_endpoint;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  copcom_if bus ();

  copcom_endpoint #(.FIFO_DEPTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Byte-wise CRC-16/CCITT reference (MSB first, no reflection)
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus.COPCRCEN = '0; bus.COPCRCINIT1 = '0; bus.COPCRCINIT2 = '0;
    bus.COPCRCI1 = '0; bus.COPCRCI2 = '0; bus.COPWR = '0; bus.COPWREN = '0;
    bus.COPWRLN = '0; bus.COPRDEN = '0; bus.tx_ready = 1'b0;
    bus.rx_data = '0; bus.rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    zero_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic crc_seed(input logic [15:0] s);
    bus.COPCRCINIT1 = s[15:8];
    bus.COPCRCINIT2 = s[7:0];
    bus.COPCRCEN = 8'h01;
    step();
    bus.COPCRCEN = 8'h00;
    step();
  endtask

  // Issues a process command and returns the number of busy cycles observed
  task automatic crc_proc(input logic [7:0] b1, input logic [7:0] b2, input bit two, output int n);
    bus.COPCRCI1 = b1;
    bus.COPCRCI2 = b2;
    bus.COPCRCEN = two ? 8'h06 : 8'h02;
    step();
    bus.COPCRCEN = 8'h00;
    n = 0;
    while (bus.COPCRCSTAT[0] && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic tx_push(input logic [7:0] b);
    bus.COPWR = b;
    bus.COPWREN = 8'h01;
    step();
    bus.COPWREN = 8'h00;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.COPCRCO1 !== 8'hFF) begin errors++; $display("FAIL reset_o1 got %h exp ff", bus.COPCRCO1); end
    checks++; if (bus.COPCRCO2 !== 8'hFF) begin errors++; $display("FAIL reset_o2 got %h exp ff", bus.COPCRCO2); end
    checks++; if (bus.COPCRCSTAT !== 8'h00) begin errors++; $display("FAIL reset_crcstat got %h exp 00", bus.COPCRCSTAT); end
    checks++; if (bus.COPWRSTAT !== 8'h00) begin errors++; $display("FAIL reset_wrstat got %h exp 00", bus.COPWRSTAT); end
    checks++; if (bus.COPRDSTAT !== 8'h01) begin errors++; $display("FAIL reset_rdstat got %h exp 01", bus.COPRDSTAT); end
    checks++; if (bus.COPRDLN !== 8'h00) begin errors++; $display("FAIL reset_rdln got %h exp 00", bus.COPRDLN); end
    checks++; if (bus.COPRD !== 8'h00) begin errors++; $display("FAIL reset_rd got %h exp 00", bus.COPRD); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", bus.tx_valid); end
    checks++; if (bus.rx_ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready got %b exp 1", bus.rx_ready); end
  endtask

  task automatic test_crc_check();
    logic [15:0] model;
    int n;
    do_reset();
    crc_seed(16'hFFFF);
    model = 16'hFFFF;
    for (int b = 8'h31; b <= 8'h39; b++) begin
      crc_proc(8'(b), 8'h00, 1'b0, n);
      model = ref_crc(model, 8'(b));
      checks++; if (n != 8) begin errors++; $display("FAIL crc1_busy byte %h got %0d exp 8", b, n); end
      checks++; if (bus.COPCRCSTAT !== 8'h02) begin errors++; $display("FAIL crc1_done byte %h got %h exp 02", b, bus.COPCRCSTAT); end
    end
    checks++; if ({bus.COPCRCO1, bus.COPCRCO2} !== 16'h29B1) begin errors++; $display("FAIL crc_check got %h exp 29b1", {bus.COPCRCO1, bus.COPCRCO2}); end
    checks++; if ({bus.COPCRCO1, bus.COPCRCO2} !== model) begin errors++; $display("FAIL crc_check_model got %h exp %h", {bus.COPCRCO1, bus.COPCRCO2}, model); end
  endtask

  task automatic test_crc_two();
    logic [15:0] exp;
    int n;
    do_reset();
    crc_seed(16'hFFFF);
    exp = ref_crc(ref_crc(16'hFFFF, 8'h31), 8'h32);
    bus.COPCRCI1 = 8'h31;
    bus.COPCRCI2 = 8'h32;
    bus.COPCRCEN = 8'h06;
    step();
    bus.COPCRCEN = 8'h00;
    n = 0;
    while (bus.COPCRCSTAT[0] && n < 100) begin
      bus.COPCRCEN = (n == 4) ? 8'h02 : 8'h00;
      step();
      n++;
    end
    bus.COPCRCEN = 8'h00;
    checks++; if (n != 16) begin errors++; $display("FAIL crc2_busy got %0d exp 16", n); end
    checks++; if ({bus.COPCRCO1, bus.COPCRCO2} !== exp) begin errors++; $display("FAIL crc2_value got %h exp %h", {bus.COPCRCO1, bus.COPCRCO2}, exp); end
    step();
    step();
    checks++; if (bus.COPCRCSTAT !== 8'h02) begin errors++; $display("FAIL crc2_ignored_rise got %h exp 02", bus.COPCRCSTAT); end
  endtask

  task automatic test_crc_random();
    logic [15:0] seed, model;
    logic [7:0] b1, b2;
    bit two;
    int n;
    do_reset();
    for (int it = 0; it < 6; it++) begin
      seed = 16'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      two = 1'($urandom_range(0, 1));
      crc_seed(seed);
      checks++; if ({bus.COPCRCO1, bus.COPCRCO2} !== seed) begin errors++; $display("FAIL crc_seed it %0d got %h exp %h", it, {bus.COPCRCO1, bus.COPCRCO2}, seed); end
      crc_proc(b1, b2, two, n);
      model = ref_crc(seed, b1);
      if (two) model = ref_crc(model, b2);
      checks++; if ({bus.COPCRCO1, bus.COPCRCO2} !== model) begin errors++; $display("FAIL crc_rand it %0d got %h exp %h", it, {bus.COPCRCO1, bus.COPCRCO2}, model); end
      checks++; if (n != (two ? 16 : 8)) begin errors++; $display("FAIL crc_rand_busy it %0d got %0d exp %0d", it, n, two ? 16 : 8); end
    end
    seed = 16'($urandom);
    bus.COPCRCINIT1 = seed[15:8];
    bus.COPCRCINIT2 = seed[7:0];
    bus.COPCRCEN = 8'h03;
    step();
    bus.COPCRCEN = 8'h00;
    checks++; if (bus.COPCRCSTAT !== 8'h00) begin errors++; $display("FAIL crc_load_wins_stat got %h exp 00", bus.COPCRCSTAT); end
    checks++; if ({bus.COPCRCO1, bus.COPCRCO2} !== seed) begin errors++; $display("FAIL crc_load_wins got %h exp %h", {bus.COPCRCO1, bus.COPCRCO2}, seed); end
  endtask

  task automatic test_tx_send();
    logic [7:0] got[$];
    int pat[4] = '{1, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 4; i++) tx_push(8'(8'hA0 + i));
    checks++; if (bus.COPWRSTAT !== 8'h04) begin errors++; $display("FAIL tx_count4 got %h exp 04", bus.COPWRSTAT); end
    bus.COPWRLN = 8'd3;
    bus.COPWREN = 8'h02;
    step();
    bus.COPWREN = 8'h00;
    checks++; if (bus.tx_valid !== 1'b1) begin errors++; $display("FAIL tx_valid_rise got %b exp 1", bus.tx_valid); end
    for (int k = 0; k < 8; k++) begin
      bus.tx_ready = (k < 4) ? 1'(pat[k]) : 1'b1;
      if (bus.tx_valid && bus.tx_ready) got.push_back(bus.tx_data);
      step();
    end
    bus.tx_ready = 1'b0;
    checks++; if (got.size() != 3) begin errors++; $display("FAIL tx_beats got %0d exp 3", got.size()); end
    for (int i = 0; i < got.size() && i < 3; i++) begin
      checks++; if (got[i] !== 8'(8'hA0 + i)) begin errors++; $display("FAIL tx_data[%0d] got %h exp %h", i, got[i], 8'(8'hA0 + i)); end
    end
    checks++; if (bus.COPWRSTAT !== 8'h01) begin errors++; $display("FAIL tx_after_send got %h exp 01", bus.COPWRSTAT); end
  endtask

  task automatic test_tx_flags();
    do_reset();
    for (int i = 0; i < 17; i++) tx_push(8'($urandom));
    checks++; if (bus.COPWRSTAT !== 8'h50) begin errors++; $display("FAIL tx_overflow got %h exp 50", bus.COPWRSTAT); end
    bus.COPWRLN = 8'd20;
    bus.COPWREN = 8'h02;
    bus.tx_ready = 1'b1;
    step();
    bus.COPWREN = 8'h00;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_underrun_valid got %b exp 0", bus.tx_valid); end
    checks++; if (bus.COPWRSTAT !== 8'hD0) begin errors++; $display("FAIL tx_underrun got %h exp d0", bus.COPWRSTAT); end
    bus.COPWREN = 8'h80;
    step();
    bus.COPWREN = 8'h00;
    checks++; if (bus.COPWRSTAT !== 8'h10) begin errors++; $display("FAIL tx_clear got %h exp 10", bus.COPWRSTAT); end
    bus.COPWRLN = 8'd0;
    bus.COPWREN = 8'h02;
    step();
    bus.COPWREN = 8'h00;
    checks++; if (bus.COPWRSTAT !== 8'h90 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL tx_len0 got %h/%b exp 90/0", bus.COPWRSTAT, bus.tx_valid); end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_rx_fill_drain();
    logic [7:0] q[$];
    logic [7:0] exp;
    bit rdy;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.rx_data = 8'(8'hB0 + i);
      bus.rx_valid = 1'b1;
      rdy = (q.size() < 16);
      checks++; if (bus.rx_ready !== rdy) begin errors++; $display("FAIL rx_ready beat %0d got %b exp %b", i, bus.rx_ready, rdy); end
      checks++; if (bus.COPRDLN !== 8'(q.size())) begin errors++; $display("FAIL rx_len beat %0d got %h exp %h", i, bus.COPRDLN, 8'(q.size())); end
      step();
      if (rdy) q.push_back(8'(8'hB0 + i));
    end
    bus.rx_valid = 1'b0;
    checks++; if (bus.COPRDSTAT !== 8'h02) begin errors++; $display("FAIL rx_full_stat got %h exp 02", bus.COPRDSTAT); end
    checks++; if (bus.COPRDLN !== 8'd16) begin errors++; $display("FAIL rx_full_len got %h exp 10", bus.COPRDLN); end
    for (int i = 0; i < 17; i++) begin
      exp = (q.size() > 0) ? q.pop_front() : 8'h00;
      checks++; if (bus.COPRD !== exp) begin errors++; $display("FAIL rx_pop %0d got %h exp %h", i, bus.COPRD, exp); end
      bus.COPRDEN = 8'h01;
      step();
      bus.COPRDEN = 8'h00;
      step();
    end
    checks++; if (bus.COPRDSTAT !== 8'h05) begin errors++; $display("FAIL rx_underflow got %h exp 05", bus.COPRDSTAT); end
    bus.COPRDEN = 8'h80;
    step();
    bus.COPRDEN = 8'h00;
    checks++; if (bus.COPRDSTAT !== 8'h01) begin errors++; $display("FAIL rx_clear got %h exp 01", bus.COPRDSTAT); end
  endtask

  task automatic test_rx_random();
    logic [7:0] q[$];
    logic [7:0] d, exp_rd, exp_stat;
    bit lvl, last, rise, vld, rdy, udf;
    do_reset();
    last = 1'b0;
    udf = 1'b0;
    for (int c = 0; c < 300; c++) begin
      lvl = 1'($urandom_range(0, 1));
      vld = ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      rise = lvl & ~last;
      last = lvl;
      rdy = (q.size() < 16);
      bus.COPRDEN = {7'b0, lvl};
      bus.rx_valid = vld;
      bus.rx_data = d;
      checks++; if (bus.rx_ready !== rdy) begin errors++; $display("FAIL rxr_ready cyc %0d got %b exp %b", c, bus.rx_ready, rdy); end
      step();
      if (rise) begin
        if (q.size() == 0) udf = 1'b1;
        else void'(q.pop_front());
      end
      if (vld && rdy) q.push_back(d);
      exp_rd = (q.size() > 0) ? q[0] : 8'h00;
      exp_stat = {5'b0, udf, q.size() == 16, q.size() == 0};
      checks++; if (bus.COPRDLN !== 8'(q.size())) begin errors++; $display("FAIL rxr_len cyc %0d got %h exp %h", c, bus.COPRDLN, 8'(q.size())); end
      checks++; if (bus.COPRD !== exp_rd) begin errors++; $display("FAIL rxr_head cyc %0d got %h exp %h", c, bus.COPRD, exp_rd); end
      checks++; if (bus.COPRDSTAT !== exp_stat) begin errors++; $display("FAIL rxr_stat cyc %0d got %h exp %h", c, bus.COPRDSTAT, exp_stat); end
    end
    bus.COPRDEN = 8'h00;
    bus.rx_valid = 1'b0;
  endtask

  task automatic test_reset_behaviour();
    zero_inputs();
    bus.COPWR = 8'h55;
    bus.COPWREN = 8'h01;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    checks++; if (bus.COPWRSTAT !== 8'h00) begin errors++; $display("FAIL rst_hold_push got %h exp 00", bus.COPWRSTAT); end
    bus.COPWREN = 8'h00;
    step();
    for (int i = 0; i < 3; i++) tx_push(8'($urandom));
    bus.COPWRLN = 8'd3;
    bus.COPWREN = 8'h02;
    bus.COPCRCI1 = 8'h5A;
    bus.COPCRCEN = 8'h02;
    step();
    bus.COPWREN = 8'h00;
    bus.COPCRCEN = 8'h00;
    step();
    checks++; if (bus.tx_valid !== 1'b1 || bus.COPCRCSTAT !== 8'h01) begin errors++; $display("FAIL rst_pre_state got %b/%h exp 1/01", bus.tx_valid, bus.COPCRCSTAT); end
    rst = 1'b1;
    step();
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_send_valid got %b exp 0", bus.tx_valid); end
    checks++; if (bus.COPWRSTAT !== 8'h00) begin errors++; $display("FAIL rst_mid_send_stat got %h exp 00", bus.COPWRSTAT); end
    checks++; if ({bus.COPCRCSTAT, bus.COPCRCO1, bus.COPCRCO2} !== 24'h00FFFF) begin errors++; $display("FAIL rst_mid_crc got %h exp 00ffff", {bus.COPCRCSTAT, bus.COPCRCO1, bus.COPCRCO2}); end
    rst = 1'b0;
    step();
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_crc_check();
    test_crc_two();
    test_crc_random();
    test_tx_send();
    test_tx_flags();
    test_rx_fill_drain();
    test_rx_random();
    test_reset_behaviour();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
